// File: rtl/arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module   : arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr
// Purpose  : DEPTH-stage valid/ready flop pipeline for array read data.
//            Bubbles collapse, full throughput, synchronous flush and
//            occupancy count. Optional even parity per stage, enabled by
//            ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr #(
  parameter int DWIDTH = 104,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [DWIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         out_par_err
);

  localparam int c_OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][DWIDTH-1:0] r_data;
  logic [DEPTH:0]               w_rdy;      // w_rdy[DEPTH] is the downstream ready
  logic [DEPTH-1:0]             w_load;     // data load enable per stage
  logic [DEPTH-1:0]             w_vld_nxt;

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN
  logic [DEPTH-1:0]             r_par;
`endif

  assign w_rdy[DEPTH] = out_rdy;
  assign in_rdy       = w_rdy[0] & ~flush;
  assign out_vld      = r_vld[DEPTH-1];
  assign out_data     = r_data[DEPTH-1];

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      // A stage can take data if it or any stage downstream of it has a hole,
      // or the consumer accepts. Written without a ripple chain on purpose.
      assign w_rdy[i] = out_rdy | ~(&r_vld[DEPTH-1:i]);

      if (i == 0) begin : g_first
        assign w_load[i]    = in_vld & in_rdy;
        assign w_vld_nxt[i] = w_load[i] | (r_vld[i] & ~w_rdy[i+1]);

        // Stage 0 captures the upstream payload on an accepted input.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_data[i] <= '0;
          end else if (w_load[i]) begin
            r_data[i] <= in_data;
          end
        end

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN
        // Parity is generated once at input and then travels with the beat.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_par[i] <= 1'b0;
          end else if (w_load[i]) begin
            r_par[i] <= ^in_data;
          end
        end
`endif
      end else begin : g_rest
        // Data movement is suppressed during flush so registers hold.
        assign w_load[i]    = r_vld[i-1] & w_rdy[i] & ~flush;
        assign w_vld_nxt[i] = (r_vld[i-1] & w_rdy[i]) | (r_vld[i] & ~w_rdy[i+1]);

        // Later stages capture from the previous stage on a forward transfer.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_data[i] <= '0;
          end else if (w_load[i]) begin
            r_data[i] <= r_data[i-1];
          end
        end

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN
        // Stored parity shifts alongside its data.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_par[i] <= 1'b0;
          end else if (w_load[i]) begin
            r_par[i] <= r_par[i-1];
          end
        end
`endif
      end
    end
  endgenerate

  // Valid bits: reset wins over flush, flush wins over handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      r_vld <= w_vld_nxt;
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + c_OCC_W'(r_vld[k]);
    end
  end

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN
  assign out_par_err = out_vld & ((^out_data) != r_par[DEPTH-1]);
`else
  assign out_par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr
// Purpose  : Scoreboard bench for the valid/ready flop pipeline
//            (DWIDTH=8, DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_vld;
  logic              in_rdy;
  logic [DWIDTH-1:0] in_data;
  logic              out_vld;
  logic              out_rdy;
  logic [DWIDTH-1:0] out_data;
  logic [1:0]        occ;
  logic              out_par_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DWIDTH-1:0] sb_q[$];

  arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .occ        (occ),
    .out_par_err(out_par_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge and stay put until the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: observe handshakes mid-cycle, when everything is settled.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_vld && out_rdy) begin
        if (sb_q.size() == 0) chk("sb_unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
        else                  chk("sb_data", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
      end
      if (in_vld && in_rdy) sb_q.push_back(in_data);
      if (flush) sb_q.delete();
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_vld = 1'b1; in_data = 8'hAA; out_rdy = 1'b0;

    // ---------------- reset ----------------
    step(); step();
    chk("rst_out_vld", {31'h0, out_vld}, 0);
    chk("rst_out_data", {24'h0, out_data}, 0);
    chk("rst_occ", {30'h0, occ}, 0);
    chk("rst_par_err", {31'h0, out_par_err}, 0);
    rst = 1'b1; in_vld = 1'b0;
    #1;
    chk("rst_in_rdy", {31'h0, in_rdy}, 1);

    // ---------------- streaming ----------------
    out_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_vld = 1'b1; in_data = DWIDTH'(k);
      step();
      if (k < 3) begin
        chk("stream_lat_vld", {31'h0, out_vld}, 0);
      end else begin
        chk("stream_vld", {31'h0, out_vld}, 1);
        chk("stream_data", {24'h0, out_data}, k - 2);
        chk("stream_par_err", {31'h0, out_par_err}, 0);
      end
    end
    in_vld = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("stream_drain_occ", {30'h0, occ}, 0);

    // ---------------- backpressure ----------------
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_data = 8'h44; #1;
    chk("bp_occ_full", {30'h0, occ}, 3);
    chk("bp_in_rdy_full", {31'h0, in_rdy}, 0);
    step(); step();
    chk("bp_hold_occ", {30'h0, occ}, 3);
    chk("bp_hold_data", {24'h0, out_data}, 32'h11);
    out_rdy = 1'b1; #1;
    chk("bp_in_rdy_pass", {31'h0, in_rdy}, 1);
    step();
    in_vld = 1'b0;
    chk("bp_occ_swap", {30'h0, occ}, 3);
    chk("bp_out_next", {24'h0, out_data}, 32'h22);
    for (int k = 0; k < 5; k++) step();
    chk("bp_drain_occ", {30'h0, occ}, 0);

    // ---------------- bubble collapse ----------------
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'h55; step();
    in_vld = 1'b0; step(); step();
    in_vld = 1'b1; in_data = 8'h66; step();
    in_vld = 1'b0; step();
    chk("bub_occ", {30'h0, occ}, 2);
    chk("bub_stage2", {24'h0, dut.r_data[2]}, 32'h55);
    chk("bub_stage1", {24'h0, dut.r_data[1]}, 32'h66);
    chk("bub_out_vld", {31'h0, out_vld}, 1);
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("bub_drain_occ", {30'h0, occ}, 0);

    // ---------------- flush ----------------
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3; step();
    chk("fl_occ_pre", {30'h0, occ}, 3);
    in_data = 8'hA4; out_rdy = 1'b1; flush = 1'b1; #1;
    chk("fl_in_rdy", {31'h0, in_rdy}, 0);
    chk("fl_head", {24'h0, out_data}, 32'hA1);
    step();
    flush = 1'b0; in_vld = 1'b0;
    chk("fl_occ_post", {30'h0, occ}, 0);
    chk("fl_out_vld", {31'h0, out_vld}, 0);
    for (int k = 0; k < 5; k++) step();
    chk("fl_no_stale", {30'h0, occ}, 0);

    // ---------------- parity ----------------
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'h0F; step();
    in_vld = 1'b0; step(); step();
    chk("par_clean", {31'h0, out_par_err}, 0);
`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN
    force dut.r_data[2][0] = 1'b0;
    #1;
    chk("par_inject", {31'h0, out_par_err}, 1);
    release dut.r_data[2][0];
    #1;
`else
    chk("par_tied_off", {31'h0, out_par_err}, 0);
`endif
    // Discard the parity beat without handing it to the consumer.
    flush = 1'b1; step();
    flush = 1'b0; step();
    chk("par_flush_occ", {30'h0, occ}, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr.md
Name: arf104b256e1r1w0cbbehcaa4acw_msff_pipe_vr

Overview:
- Parametrised multi-stage flop pipeline with a valid/ready handshake. It supersedes the single-stage phase-A flop used on array read/write datapaths.
- Each stage holds data until the downstream stage can take it. Bubbles collapse, so the pipeline sustains 1 transfer/cycle.
- Provides a synchronous flush and an occupancy count.
- Sits between the array read port and consumer logic so that read data can be retimed across DEPTH cycles under backpressure.

Parameters:
- DWIDTH, 104: payload width in bits; legal range 1 and up.
- DEPTH, 2: number of register stages; legal range 1 and up. Stage 0 is nearest the input; stage DEPTH-1 drives the output.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-low.
- flush  input  1  synchronous clear of all stage valid bits.
- in_vld  input  1  upstream data valid.
- in_rdy  output  1  pipeline can accept this cycle.
- in_data  input  DWIDTH  upstream payload.
- out_vld  output  1  output stage holds valid data.
- out_rdy  input  1  downstream accepts this cycle.
- out_data  output  DWIDTH  output stage payload.
- occ  output  $clog2(DEPTH+1)  number of valid stages.
- out_par_err  output  1  parity error flag; see Optional Feature.

Behaviour:
- Reset (rst==0 at a clk edge): all stage valid bits clear to 0; all stage data registers clear to 0. Resulting values: out_vld=0, out_data=0, occ=0, out_par_err=0. Reset overrides flush and any handshake in the same cycle.
- Per-stage ready (combinational):
  - rdy[DEPTH-1] = ~vld[DEPTH-1] | out_rdy
  - rdy[i] = ~vld[i] | rdy[i+1]
  - in_rdy = rdy[0] & ~flush
- Transfers:
  - Input accepted when in_vld & in_rdy; it loads stage 0.
  - Stage i moves to stage i+1 when vld[i] & rdy[i+1].
  - Output transfer when out_vld & out_rdy.
- Valid update:
  - vld[0] next = (in_vld & in_rdy) | (vld[0] & ~rdy[1])
  - vld[i] next = (vld[i-1] & rdy[i]) | (vld[i] & ~rdy[i+1]), where rdy[DEPTH] means out_rdy.
  - For DEPTH==1, stage 0 follows the same rule, using out_rdy in place of rdy[1].
- Data registers load only on an accepting transfer into that stage. Otherwise they hold, and stalled data stays stable.
- Latency: data accepted at edge N appears on out_data with out_vld=1 after edge N+DEPTH-1 when no stage is stalled. A value present on in_data before edge N is visible at the output DEPTH edges later.
- Throughput: 1 beat/cycle with out_rdy held at 1. Any bubble in the pipe is filled while downstream stalls; up to DEPTH beats are buffered.
- Full (all vld=1, out_rdy=0): in_rdy=0 and nothing moves. When out_rdy rises, in_rdy=1 in the same cycle (combinational pass-through). Accept and output happen on the same edge.
- Empty: out_vld=0; out_data holds its last value (don't-care to consumers).
- Ordering: strict FIFO; no beat is duplicated or dropped except by flush or reset.
- Flush (rst==1, flush==1): all vld clear at the edge, data registers hold, and in_rdy=0 that cycle.
  - An output transfer still completes if out_vld & out_rdy are both high in the flush cycle; the consumer sees it.
  - Beats not transferred are discarded.
- occ = popcount(vld), driven combinationally from the registers. Range 0..DEPTH.
- out_data is driven directly from the stage DEPTH-1 register, with no output logic.

Optional Feature:
- Macro: ARF104B256E1R1W0CBBEHCAA4ACW_MSFF_PIPE_PARITY_EN.
- Defined:
  - Each stage stores one extra even-parity bit, computed as ^in_data at input accept. It travels with the data.
  - out_par_err = out_vld & (^out_data != stored parity), combinational. It resets to 0 and is 0 when out_vld=0.
- Not defined: no parity storage; out_par_err tied to 0. Handshake and timing are identical in both builds.

Test Plan (DWIDTH=8, DEPTH=3):
- Reset: hold rst=0 for 2 cycles with in_vld=1 and in_data=8'hAA -> out_vld=0, out_data=8'h00, occ=0, in_rdy=1 after release.
- Streaming: out_rdy=1; send 8'h01..8'h08 on consecutive cycles -> out_data is 8'h01 with out_vld=1 exactly 3 edges after the first input edge. Then one value per cycle in order, no gaps.
- Backpressure: out_rdy=0; send 8'h11,8'h22,8'h33,8'h44 -> first three accepted, occ=3, in_rdy=0 with 8'h44 held. Raise out_rdy -> 8'h44 accepted on the same edge 8'h11 leaves; output order is 11,22,33,44.
- Bubble collapse: out_rdy=0; send 8'h55, idle 2 cycles, then send 8'h66 -> occ=2, and 8'h55 sits in stage 2 with 8'h66 in stage 1.
- Flush: occ=3 and out_rdy=1, assert flush for 1 cycle -> the head beat transfers, occ=0 after the edge, in_rdy=0 during flush, and no stale beats appear afterwards.
- Parity (macro defined): force stage-2 data bit 0 to flip while holding 8'h0F -> out_par_err=1 while out_vld=1. With the macro undefined -> out_par_err stays 0.
